// File: rtl/risc_v_mike_pkg.sv
// Shared types for the risc_v_mike slice, plus the common async active-low flop macro.
`ifndef RISC_V_MIKE_DFF_ARN
`define RISC_V_MIKE_DFF_ARN(q, d, rv, clk, rst_n) \
    always_ff @(posedge clk or negedge rst_n) begin \
        if (!rst_n) q <= (rv); \
        else q <= (d); \
    end
`endif

package risc_v_mike_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_32_W  = 32;

    typedef logic [REG_ADDR_W-1:0] t_register_addr;

    typedef struct packed {
        logic                 valid;
        t_register_addr       addr;
        logic [DATA_32_W-1:0] data;
    } t_wb_req;

    // Bit 0 of a busy vector is always 0, so the count never exceeds 31.
    function automatic logic [4:0] popcount32(input logic [31:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 5'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/risc_v_mike_wb_scheduler_if.sv
// Issue query, two writeback requesters and the register-file write port of the scheduler.
interface risc_v_mike_wb_scheduler_if
    import risc_v_mike_pkg::*;
#(
    parameter int DATA_W = DATA_32_W
);
    logic              iss_valid;
    t_register_addr    iss_rd;
    t_register_addr    iss_rs1;
    t_register_addr    iss_rs2;
    logic              iss_stall;

    logic              alu_wb_valid;
    t_register_addr    alu_wb_addr;
    logic [DATA_W-1:0] alu_wb_data;
    logic              alu_wb_ready;

    logic              ld_wb_valid;
    t_register_addr    ld_wb_addr;
    logic [DATA_W-1:0] ld_wb_data;
    logic              ld_wb_ready;

    logic              reg_file_write;
    t_register_addr    reg_file_wr_addr;
    logic [DATA_W-1:0] reg_file_wr_data;

    modport master (
        output iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  iss_stall,
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  alu_wb_ready,
        output ld_wb_valid, ld_wb_addr, ld_wb_data,
        input  ld_wb_ready,
        input  reg_file_write, reg_file_wr_addr, reg_file_wr_data
    );

    modport slave (
        input  iss_valid, iss_rd, iss_rs1, iss_rs2,
        output iss_stall,
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        output alu_wb_ready,
        input  ld_wb_valid, ld_wb_addr, ld_wb_data,
        output ld_wb_ready,
        output reg_file_write, reg_file_wr_addr, reg_file_wr_data
    );
endinterface

// File: rtl/risc_v_mike_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational from requests and last_grant.
module risc_v_mike_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_grant_reg;
    logic last_grant_next;

    always_comb begin
        gnt             = 2'b00;
        last_grant_next = last_grant_reg;
        if (!rst) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = last_grant_reg ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
        if (gnt != 2'b00) last_grant_next = gnt[1];
    end

    // Reset to the load requester so the ALU wins the first tie.
    `RISC_V_MIKE_DFF_ARN(last_grant_reg, last_grant_next, 1'b1, clk, rst)
endmodule

// File: rtl/risc_v_mike_wb_scheduler.sv
// Writeback scheduler: busy-register scoreboard for issue, ALU/load arbitration, 1-cycle write stage.
module risc_v_mike_wb_scheduler
    import risc_v_mike_pkg::*;
#(
    parameter int REG_FILE_DEPTH = 16,
    parameter int DATA_W         = DATA_32_W
) (
    input  logic                       clk,
    input  logic                       rst,
    risc_v_mike_wb_scheduler_if.slave  bus,
    output logic [4:0]                 pending_cnt,
    output logic                       wb_err
);
    localparam int NUM_ADDR = 1 << REG_ADDR_W;

    logic [REG_FILE_DEPTH-1:0] busy_reg;
    logic [REG_FILE_DEPTH-1:0] busy_next;
    logic [NUM_ADDR-1:0]       busy_ext;
    logic [1:0]                gnt;
    logic                      accept;
    logic                      iss_stall;
    logic                      iss_fire;
    logic                      wr_valid_reg, wr_valid_next;
    logic                      wb_err_reg, wb_err_next;
    t_register_addr            sel_addr, wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]         sel_data, wr_data_reg, wr_data_next;

    // Zero-extended so any encodable address indexes safely; out-of-range entries read as idle.
    assign busy_ext = NUM_ADDR'(busy_reg);

    assign iss_stall = bus.iss_valid &
                       (busy_ext[bus.iss_rs1] | busy_ext[bus.iss_rs2] | busy_ext[bus.iss_rd]);
    assign iss_fire  = bus.iss_valid & ~iss_stall & (bus.iss_rd != '0);

    risc_v_mike_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bus.ld_wb_valid, bus.alu_wb_valid}),
        .gnt (gnt)
    );

    assign accept   = |gnt;
    assign sel_addr = gnt[1] ? bus.ld_wb_addr : bus.alu_wb_addr;
    assign sel_data = gnt[1] ? bus.ld_wb_data : bus.alu_wb_data;

    // A clear lands on the edge the register file is written; set and clear never share an address.
    assign busy_next[0] = 1'b0;
    for (genvar gi = 1; gi < REG_FILE_DEPTH; gi++) begin : g_busy
        assign busy_next[gi] =
            (busy_reg[gi] & ~(wr_valid_reg && (wr_addr_reg == t_register_addr'(gi)))) |
            (iss_fire && (bus.iss_rd == t_register_addr'(gi)));
    end

    assign wr_valid_next = accept && (sel_addr != '0);
    assign wr_addr_next  = accept ? sel_addr : wr_addr_reg;
    assign wr_data_next  = accept ? sel_data : wr_data_reg;
    assign wb_err_next   = wb_err_reg |
                           (accept && (sel_addr != '0) && !busy_ext[sel_addr]);

    `RISC_V_MIKE_DFF_ARN(busy_reg, busy_next, '0, clk, rst)
    `RISC_V_MIKE_DFF_ARN(wr_valid_reg, wr_valid_next, 1'b0, clk, rst)
    `RISC_V_MIKE_DFF_ARN(wr_addr_reg, wr_addr_next, '0, clk, rst)
    `RISC_V_MIKE_DFF_ARN(wr_data_reg, wr_data_next, '0, clk, rst)
    `RISC_V_MIKE_DFF_ARN(wb_err_reg, wb_err_next, 1'b0, clk, rst)

    assign bus.iss_stall        = iss_stall;
    assign bus.alu_wb_ready     = gnt[0];
    assign bus.ld_wb_ready      = gnt[1];
    assign bus.reg_file_write   = wr_valid_reg;
    assign bus.reg_file_wr_addr = wr_addr_reg;
    assign bus.reg_file_wr_data = wr_data_reg;
    assign pending_cnt          = popcount32(busy_ext);
    assign wb_err               = wb_err_reg;
endmodule

// File: tb/tb_risc_v_mike_wb_scheduler.sv
// Scenario bench for the writeback scheduler; expected writes are queued and matched as they appear.
module tb_risc_v_mike_wb_scheduler;
    import risc_v_mike_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] pending_cnt;
    logic       wb_err;
    int         n_checks = 0;
    int         n_fail   = 0;
    t_wb_req    exp_q[$];

    always #5 clk = ~clk;

    risc_v_mike_wb_scheduler_if #(.DATA_W(DATA_32_W)) bus ();

    risc_v_mike_wb_scheduler #(.REG_FILE_DEPTH(16), .DATA_W(DATA_32_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    // Every register-file write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.reg_file_write === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got write addr=%0d data=%08h, required no write",
                         bus.reg_file_wr_addr, bus.reg_file_wr_data);
            end else begin
                t_wb_req e;
                e = exp_q.pop_front();
                if (bus.reg_file_wr_addr !== e.addr || bus.reg_file_wr_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             bus.reg_file_wr_addr, bus.reg_file_wr_data, e.addr, e.data);
                end else begin
                    $display("wb write addr=%0d data=%08h", bus.reg_file_wr_addr, bus.reg_file_wr_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input t_register_addr a, input logic [31:0] d);
        t_wb_req e;
        e.valid = 1'b1;
        e.addr  = a;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.iss_valid    = 1'b0;
        bus.iss_rd       = '0;
        bus.iss_rs1      = '0;
        bus.iss_rs2      = '0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_addr  = '0;
        bus.alu_wb_data  = '0;
        bus.ld_wb_valid  = 1'b0;
        bus.ld_wb_addr   = '0;
        bus.ld_wb_data   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic issue(input t_register_addr rd);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = rd;
        bus.iss_rs1   = '0;
        bus.iss_rs2   = '0;
        tick();
        bus.iss_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        bus.alu_wb_valid = 1'b1;
        bus.ld_wb_valid  = 1'b1;
        bus.iss_valid    = 1'b1;
        bus.iss_rs1      = 5'd1;
        tick();
        tick();
        n_checks++; if (bus.reg_file_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b required 0", bus.reg_file_write); end
        n_checks++; if (bus.reg_file_wr_addr !== 5'd0) begin n_fail++; $display("FAIL rst_addr: got %0d required 0", bus.reg_file_wr_addr); end
        n_checks++; if (bus.reg_file_wr_data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %08h required 0", bus.reg_file_wr_data); end
        n_checks++; if (pending_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_pending: got %0d required 0", pending_cnt); end
        n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b required 0", bus.iss_stall); end
        n_checks++; if (bus.alu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready: got %b required 0", bus.alu_wb_ready); end
        n_checks++; if (bus.ld_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready: got %b required 0", bus.ld_wb_ready); end
        n_checks++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL rst_wb_err: got %b required 0", wb_err); end
        idle();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_alu();
        issue(5'd5);
        #1;
        n_checks++; if (pending_cnt !== 5'd1) begin n_fail++; $display("FAIL single_pending_set: got %0d required 1", pending_cnt); end
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = 5'd5;
        bus.alu_wb_data  = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.alu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready: got %b required 1", bus.alu_wb_ready); end
        push(5'd5, 32'hDEADBEEF);
        tick();
        bus.alu_wb_valid = 1'b0;
        n_checks++; if (bus.reg_file_write !== 1'b1) begin n_fail++; $display("FAIL single_write: got %b required 1", bus.reg_file_write); end
        n_checks++; if (bus.reg_file_wr_addr !== 5'd5) begin n_fail++; $display("FAIL single_addr: got %0d required 5", bus.reg_file_wr_addr); end
        n_checks++; if (bus.reg_file_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %08h required deadbeef", bus.reg_file_wr_data); end
        tick();
        n_checks++; if (bus.reg_file_write !== 1'b0) begin n_fail++; $display("FAIL single_write_drop: got %b required 0", bus.reg_file_write); end
        n_checks++; if (pending_cnt !== 5'd0) begin n_fail++; $display("FAIL single_pending_clr: got %0d required 0", pending_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        issue(5'd3);
        issue(5'd4);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd3; bus.alu_wb_data = 32'hA0A0_0003;
        bus.ld_wb_valid  = 1'b1; bus.ld_wb_addr  = 5'd4; bus.ld_wb_data  = 32'hB0B0_0004;
        #1;
        n_checks++; if ({bus.ld_wb_ready, bus.alu_wb_ready} !== 2'b01) begin n_fail++; $display("FAIL sim_first_grant: got %b required 01", {bus.ld_wb_ready, bus.alu_wb_ready}); end
        push(5'd3, 32'hA0A0_0003);
        tick();
        bus.alu_wb_valid = 1'b0;
        #1;
        n_checks++; if ({bus.ld_wb_ready, bus.alu_wb_ready} !== 2'b10) begin n_fail++; $display("FAIL sim_second_grant: got %b required 10", {bus.ld_wb_ready, bus.alu_wb_ready}); end
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.reg_file_wr_addr !== 5'd3) begin n_fail++; $display("FAIL sim_write3: got write=%b addr=%0d required 1/3", bus.reg_file_write, bus.reg_file_wr_addr); end
        push(5'd4, 32'hB0B0_0004);
        tick();
        bus.ld_wb_valid = 1'b0;
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.reg_file_wr_addr !== 5'd4) begin n_fail++; $display("FAIL sim_write4: got write=%b addr=%0d required 1/4", bus.reg_file_write, bus.reg_file_wr_addr); end
        n_checks++; if (pending_cnt !== 5'd1) begin n_fail++; $display("FAIL sim_pending_mid: got %0d required 1", pending_cnt); end
        tick();
        n_checks++; if (pending_cnt !== 5'd0) begin n_fail++; $display("FAIL sim_pending_end: got %0d required 0", pending_cnt); end
    endtask

    task automatic test_back_to_back();
        issue(5'd10);
        issue(5'd11);
        issue(5'd12);
        #1;
        n_checks++; if (pending_cnt !== 5'd3) begin n_fail++; $display("FAIL b2b_pending: got %0d required 3", pending_cnt); end
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd10; bus.alu_wb_data = 32'h0000_0010;
        bus.ld_wb_valid  = 1'b1; bus.ld_wb_addr  = 5'd11; bus.ld_wb_data  = 32'h0000_0011;
        #1;
        n_checks++; if ({bus.ld_wb_ready, bus.alu_wb_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_tie_alu: got %b required 01", {bus.ld_wb_ready, bus.alu_wb_ready}); end
        push(5'd10, 32'h0000_0010);
        tick();
        bus.alu_wb_addr = 5'd12; bus.alu_wb_data = 32'h0000_0012;
        #1;
        n_checks++; if ({bus.ld_wb_ready, bus.alu_wb_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_tie_ld: got %b required 10", {bus.ld_wb_ready, bus.alu_wb_ready}); end
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.reg_file_wr_addr !== 5'd10) begin n_fail++; $display("FAIL b2b_write10: got write=%b addr=%0d required 1/10", bus.reg_file_write, bus.reg_file_wr_addr); end
        push(5'd11, 32'h0000_0011);
        tick();
        bus.ld_wb_valid = 1'b0;
        #1;
        n_checks++; if (bus.alu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_alu_alone: got %b required 1", bus.alu_wb_ready); end
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.reg_file_wr_addr !== 5'd11) begin n_fail++; $display("FAIL b2b_write11: got write=%b addr=%0d required 1/11", bus.reg_file_write, bus.reg_file_wr_addr); end
        push(5'd12, 32'h0000_0012);
        tick();
        bus.alu_wb_valid = 1'b0;
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.reg_file_wr_addr !== 5'd12) begin n_fail++; $display("FAIL b2b_write12: got write=%b addr=%0d required 1/12", bus.reg_file_write, bus.reg_file_wr_addr); end
        tick();
        n_checks++; if (bus.reg_file_write !== 1'b0 || pending_cnt !== 5'd0) begin n_fail++; $display("FAIL b2b_idle: got write=%b pending=%0d required 0/0", bus.reg_file_write, pending_cnt); end
    endtask

    task automatic test_raw_stall();
        issue(5'd7);
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd8; bus.iss_rs1 = 5'd7; bus.iss_rs2 = 5'd0;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall0: got %b required 1", bus.iss_stall); end
        tick();
        n_checks++; if (bus.iss_stall !== 1'b1 || pending_cnt !== 5'd1) begin n_fail++; $display("FAIL raw_stall1: got stall=%b pending=%0d required 1/1", bus.iss_stall, pending_cnt); end
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd7; bus.alu_wb_data = 32'h7777_0007;
        push(5'd7, 32'h7777_0007);
        tick();
        bus.alu_wb_valid = 1'b0;
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_write_cycle: got write=%b stall=%b required 1/1", bus.reg_file_write, bus.iss_stall); end
        tick();
        n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_fall: got %b required 0", bus.iss_stall); end
        tick();
        bus.iss_valid = 1'b0;
        n_checks++; if (pending_cnt !== 5'd1) begin n_fail++; $display("FAIL raw_claim8: got %0d required 1", pending_cnt); end
        bus.ld_wb_valid = 1'b1; bus.ld_wb_addr = 5'd8; bus.ld_wb_data = 32'h8888_0008;
        push(5'd8, 32'h8888_0008);
        tick();
        bus.ld_wb_valid = 1'b0;
        tick();
        n_checks++; if (pending_cnt !== 5'd0) begin n_fail++; $display("FAIL raw_clear8: got %0d required 0", pending_cnt); end
    endtask

    task automatic test_x0();
        issue(5'd2);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd0; bus.alu_wb_data = 32'h1234_5678;
        #1;
        n_checks++; if (bus.alu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b required 1", bus.alu_wb_ready); end
        tick();
        bus.alu_wb_valid = 1'b0;
        n_checks++; if (bus.reg_file_write !== 1'b0) begin n_fail++; $display("FAIL x0_no_write: got %b required 0", bus.reg_file_write); end
        n_checks++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL x0_wb_err: got %b required 0", wb_err); end
        n_checks++; if (pending_cnt !== 5'd1) begin n_fail++; $display("FAIL x0_busy_kept: got %0d required 1", pending_cnt); end
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd2; bus.alu_wb_data = 32'h2222_0002;
        push(5'd2, 32'h2222_0002);
        tick();
        bus.alu_wb_valid = 1'b0;
        tick();
        n_checks++; if (pending_cnt !== 5'd0 || wb_err !== 1'b0) begin n_fail++; $display("FAIL x0_cleanup: got pending=%0d wb_err=%b required 0/0", pending_cnt, wb_err); end
    endtask

    task automatic test_spurious();
        bus.ld_wb_valid = 1'b1; bus.ld_wb_addr = 5'd9; bus.ld_wb_data = 32'h9999_0009;
        #1;
        n_checks++; if (bus.ld_wb_ready !== 1'b1) begin n_fail++; $display("FAIL spur_ready: got %b required 1", bus.ld_wb_ready); end
        push(5'd9, 32'h9999_0009);
        tick();
        bus.ld_wb_valid = 1'b0;
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.reg_file_wr_addr !== 5'd9) begin n_fail++; $display("FAIL spur_write: got write=%b addr=%0d required 1/9", bus.reg_file_write, bus.reg_file_wr_addr); end
        n_checks++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL spur_err_set: got %b required 1", wb_err); end
        tick();
        tick();
        n_checks++; if (wb_err !== 1'b1 || pending_cnt !== 5'd0) begin n_fail++; $display("FAIL spur_err_hold: got wb_err=%b pending=%0d required 1/0", wb_err, pending_cnt); end
    endtask

    task automatic test_reset_mid();
        issue(5'd6);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd6; bus.alu_wb_data = 32'h6666_0006;
        tick();
        n_checks++; if (bus.reg_file_write !== 1'b1 || bus.reg_file_wr_addr !== 5'd6) begin n_fail++; $display("FAIL mid_stage_loaded: got write=%b addr=%0d required 1/6", bus.reg_file_write, bus.reg_file_wr_addr); end
        rst = 1'b0;
        bus.alu_wb_valid = 1'b0;
        #1;
        n_checks++; if (bus.reg_file_write !== 1'b0 || bus.reg_file_wr_data !== 32'd0) begin n_fail++; $display("FAIL mid_in_reset: got write=%b data=%08h required 0/0", bus.reg_file_write, bus.reg_file_wr_data); end
        n_checks++; if (pending_cnt !== 5'd0 || wb_err !== 1'b0) begin n_fail++; $display("FAIL mid_state_clr: got pending=%0d wb_err=%b required 0/0", pending_cnt, wb_err); end
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.reg_file_write !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse%0d: got %b required 0", i, bus.reg_file_write); end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_back_to_back();
        test_raw_stall();
        test_x0();
        test_spurious();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding writes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
